// File: rtl/sipo_loader.sv
// Serial-in, parallel-out word assembler with a framed valid/ready input and a one-cycle load strobe.
// Optional even-parity check on a trailing bit is enabled by defining SIPO_LOADER_PARITY_EN.
`timescale 1ns/1ps

module sipo_loader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  output logic             ser_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SIPO_LOADER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_LOAD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_t;
`endif

  state_t          state;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] shreg;
  logic            accept;

  // Bit ordering is fixed by which end of the shift register takes the new bit.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST)
      return {cur[WIDTH-2:0], b};
    else
      return {b, cur[WIDTH-1:1]};
  endfunction

  assign ser_ready = !rst && (state != S_LOAD);
  assign accept    = ser_valid && ser_ready;

`ifdef SIPO_LOADER_PARITY_EN
  assign busy = (state == S_SHIFT) || (state == S_PARITY);
`else
  assign busy = (state == S_SHIFT);
`endif

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see the pre-edge values, matching flop behaviour.
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      shreg     <= '0;
      data_out  <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      load      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (frame_start) begin
              shreg <= shift_in(shreg, ser_in);
              count <= CW'(1);
              state <= S_SHIFT;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (accept) begin
            if (frame_start) begin
              // Restart: stale bits are flushed out by the WIDTH shifts that follow.
              frame_err <= 1'b1;
              shreg     <= shift_in(shreg, ser_in);
              count     <= CW'(1);
            end else if (count == LAST_BIT) begin
              count <= '0;
`ifdef SIPO_LOADER_PARITY_EN
              shreg <= shift_in(shreg, ser_in);
              state <= S_PARITY;
`else
              data_out <= shift_in(shreg, ser_in);
              load     <= 1'b1;
              state    <= S_LOAD;
`endif
            end else begin
              shreg <= shift_in(shreg, ser_in);
              count <= count + CW'(1);
            end
          end
        end

`ifdef SIPO_LOADER_PARITY_EN
        S_PARITY: begin
          if (accept) begin
            if (frame_start) begin
              frame_err <= 1'b1;
              shreg     <= shift_in(shreg, ser_in);
              count     <= CW'(1);
              state     <= S_SHIFT;
            end else if (ser_in == ^shreg) begin
              data_out <= shreg;
              load     <= 1'b1;
              count    <= '0;
              state    <= S_LOAD;
            end else begin
              frame_err <= 1'b1;
              count     <= '0;
              state     <= S_IDLE;
            end
          end
        end
`endif

        S_LOAD:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_loader.sv
// Randomised and directed bench for sipo_loader: two instances (MSB-first and LSB-first) share
// the stimulus and are checked every cycle against a queue-based model of the word framing rules.
`timescale 1ns/1ps

module tb_sipo_loader;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ser_in = 1'b0;
  logic         ser_valid = 1'b0;
  logic         frame_start = 1'b0;

  logic         ready_m, load_m, busy_m, ferr_m;
  logic [W-1:0] data_m;
  logic         ready_l, load_l, busy_l, ferr_l;
  logic [W-1:0] data_l;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: accepted bits of the word in progress, last loaded words, cycle bookkeeping.
  bit           q[$];
  bit           m_in_load  = 1'b0;
  bit           m_par_wait = 1'b0;
  bit           last_acc   = 1'b0;
  logic [W-1:0] exp_data_m = '0;
  logic [W-1:0] exp_data_l = '0;
  int           cyc = 0;
  int           loads_seen = 0;
  int           ferrs_seen = 0;
  int           last_load_cyc = 0;
  int           prev_load_cyc = 0;

  sipo_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .frame_start(frame_start),
    .ser_ready(ready_m), .data_out(data_m), .load(load_m), .busy(busy_m), .frame_err(ferr_m)
  );

  sipo_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .frame_start(frame_start),
    .ser_ready(ready_l), .data_out(data_l), .load(load_l), .busy(busy_l), .frame_err(ferr_l)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] word_of(input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (msb) w[W-1-i] = q[i];
      else     w[i]     = q[i];
    end
    return w;
  endfunction

  function automatic bit parity_of_q();
    int ones;
    ones = 0;
    for (int i = 0; i < q.size(); i++) ones += int'(q[i]);
    return bit'(ones % 2);
  endfunction

  task automatic model_reset();
    q.delete();
    m_in_load  = 1'b0;
    m_par_wait = 1'b0;
    exp_data_m = '0;
    exp_data_l = '0;
  endtask

  // One clock: drive inputs, advance the model by the framing rules, compare every output.
  task automatic step(input bit valid, input bit b, input bit fs);
    bit acc, exp_load, exp_ferr;
    acc = valid && !m_in_load;
    ser_valid = valid; ser_in = b; frame_start = fs;
    @(posedge clk); #1;
    cyc++;
    exp_load = 1'b0; exp_ferr = 1'b0;
    if (acc) begin
      if (fs && q.size() > 0) begin
        exp_ferr = 1'b1; q.delete(); m_par_wait = 1'b0; q.push_back(b);
      end else if (m_par_wait) begin
        m_par_wait = 1'b0;
        if (b == parity_of_q()) begin
          exp_load = 1'b1; exp_data_m = word_of(1'b1); exp_data_l = word_of(1'b0);
        end else begin
          exp_ferr = 1'b1;
        end
        q.delete();
      end else if (q.size() == 0) begin
        if (fs) q.push_back(b);
        else    exp_ferr = 1'b1;
      end else begin
        q.push_back(b);
      end
      if (!m_par_wait && q.size() == W) begin
`ifdef SIPO_LOADER_PARITY_EN
        m_par_wait = 1'b1;
`else
        exp_load = 1'b1; exp_data_m = word_of(1'b1); exp_data_l = word_of(1'b0);
        q.delete();
`endif
      end
    end
    m_in_load = exp_load;
    last_acc  = acc;
    if (load_m) begin loads_seen++; prev_load_cyc = last_load_cyc; last_load_cyc = cyc; end
    if (ferr_m) ferrs_seen++;

    n_checks++; if (load_m !== exp_load) begin n_fail++; $display("FAIL load_msb: got %b expected %b cyc %0d", load_m, exp_load, cyc); end
    n_checks++; if (load_l !== exp_load) begin n_fail++; $display("FAIL load_lsb: got %b expected %b cyc %0d", load_l, exp_load, cyc); end
    n_checks++; if (ferr_m !== exp_ferr) begin n_fail++; $display("FAIL frame_err_msb: got %b expected %b cyc %0d", ferr_m, exp_ferr, cyc); end
    n_checks++; if (ferr_l !== exp_ferr) begin n_fail++; $display("FAIL frame_err_lsb: got %b expected %b cyc %0d", ferr_l, exp_ferr, cyc); end
    n_checks++; if (ready_m !== !m_in_load) begin n_fail++; $display("FAIL ser_ready: got %b expected %b cyc %0d", ready_m, !m_in_load, cyc); end
    n_checks++; if (busy_m !== (q.size() > 0)) begin n_fail++; $display("FAIL busy_msb: got %b expected %b cyc %0d", busy_m, (q.size() > 0), cyc); end
    n_checks++; if (busy_l !== (q.size() > 0)) begin n_fail++; $display("FAIL busy_lsb: got %b expected %b cyc %0d", busy_l, (q.size() > 0), cyc); end
    n_checks++; if (data_m !== exp_data_m) begin n_fail++; $display("FAIL data_msb: got %h expected %h cyc %0d", data_m, exp_data_m, cyc); end
    n_checks++; if (data_l !== exp_data_l) begin n_fail++; $display("FAIL data_lsb: got %h expected %h cyc %0d", data_l, exp_data_l, cyc); end
  endtask

  // Sends w first-bit-first (w[W-1] goes first), holding each bit until accepted.
  task automatic send_word(input logic [W-1:0] w, input int gap, input bit bad_par);
    for (int i = 0; i < W; i++) begin
      last_acc = 1'b0;
      for (int t = 0; t < 4 && !last_acc; t++) step(1'b1, w[W-1-i], i == 0);
      if (i < W - 1)
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
    end
`ifdef SIPO_LOADER_PARITY_EN
    last_acc = 1'b0;
    for (int t = 0; t < 4 && !last_acc; t++) step(1'b1, (^w) ^ bad_par, 1'b0);
`else
    if (bad_par) $display("note: parity not compiled in, parity flag ignored");
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; ser_valid = 1'b0; frame_start = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_checks++; if (ready_m !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready_m); end
      n_checks++; if (load_m !== 1'b0 || ferr_m !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got %b%b expected 00", load_m, ferr_m); end
      n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_m); end
      n_checks++; if (data_m !== '0 || data_l !== '0) begin n_fail++; $display("FAIL reset_data: got %h/%h expected 00/00", data_m, data_l); end
    end
    rst = 1'b0; #1;
    n_checks++; if (ready_m !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b expected 1", ready_m); end
  endtask

  task automatic test_basic_word();
    send_word(8'hB2, 0, 1'b0);
    n_checks++; if (data_m !== 8'hB2) begin n_fail++; $display("FAIL msb_first_word: got %h expected b2", data_m); end
    n_checks++; if (data_l !== 8'h4D) begin n_fail++; $display("FAIL lsb_first_word: got %h expected 4d", data_l); end
    n_checks++; if (load_m !== 1'b1 || ready_m !== 1'b0) begin n_fail++; $display("FAIL load_cycle: got load %b ready %b expected 1 0", load_m, ready_m); end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    int l0;
    l0 = loads_seen;
    send_word(8'hB2, 3, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_checks++; if (loads_seen - l0 !== 1) begin n_fail++; $display("FAIL gap_loads: got %0d expected 1", loads_seen - l0); end
    n_checks++; if (data_m !== 8'hB2) begin n_fail++; $display("FAIL gap_word: got %h expected b2", data_m); end
  endtask

  task automatic test_frame_restart();
    int l0, f0;
    l0 = loads_seen; f0 = ferrs_seen;
    step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    send_word(8'hFF, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_checks++; if (ferrs_seen - f0 !== 1) begin n_fail++; $display("FAIL restart_ferr: got %0d expected 1", ferrs_seen - f0); end
    n_checks++; if (loads_seen - l0 !== 1) begin n_fail++; $display("FAIL restart_loads: got %0d expected 1", loads_seen - l0); end
    n_checks++; if (data_m !== 8'hFF) begin n_fail++; $display("FAIL restart_word: got %h expected ff", data_m); end
  endtask

  task automatic test_idle_no_frame();
    step(1'b1, 1'b1, 1'b0);
    n_checks++; if (ferr_m !== 1'b1 || busy_m !== 1'b0) begin n_fail++; $display("FAIL idle_no_frame: got ferr %b busy %b expected 1 0", ferr_m, busy_m); end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_word();
    step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    // Reset coincides with a framed valid bit; reset must win.
    rst = 1'b1; ser_valid = 1'b1; frame_start = 1'b1; ser_in = 1'b1;
    @(posedge clk); #1;
    model_reset();
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy_m); end
    n_checks++; if (data_m !== '0) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 00", data_m); end
    n_checks++; if (load_m !== 1'b0 || ready_m !== 1'b0) begin n_fail++; $display("FAIL rst_mid_strobe: got load %b ready %b expected 0 0", load_m, ready_m); end
    rst = 1'b0; ser_valid = 1'b0; frame_start = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 0, 1'b0);
    n_checks++; if (data_m !== 8'h3C) begin n_fail++; $display("FAIL rst_mid_next_word: got %h expected 3c", data_m); end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int spacing;
`ifdef SIPO_LOADER_PARITY_EN
    spacing = W + 2;
`else
    spacing = W + 1;
`endif
    send_word(8'hA5, 0, 1'b0);
    send_word(8'h5A, 0, 1'b0);
    n_checks++; if (last_load_cyc - prev_load_cyc !== spacing) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", last_load_cyc - prev_load_cyc, spacing); end
    n_checks++; if (data_m !== 8'h5A) begin n_fail++; $display("FAIL b2b_word: got %h expected 5a", data_m); end
    step(1'b0, 1'b0, 1'b0);
  endtask

`ifdef SIPO_LOADER_PARITY_EN
  task automatic test_parity();
    int l0, f0;
    send_word(8'hB2, 0, 1'b0);
    n_checks++; if (load_m !== 1'b1 || data_m !== 8'hB2) begin n_fail++; $display("FAIL parity_good: got load %b data %h expected 1 b2", load_m, data_m); end
    step(1'b0, 1'b0, 1'b0);
    l0 = loads_seen; f0 = ferrs_seen;
    send_word(8'hB2, 0, 1'b1);
    n_checks++; if (ferr_m !== 1'b1 || load_m !== 1'b0) begin n_fail++; $display("FAIL parity_bad: got ferr %b load %b expected 1 0", ferr_m, load_m); end
    step(1'b0, 1'b0, 1'b0);
    n_checks++; if (loads_seen != l0 || ferrs_seen - f0 !== 1) begin n_fail++; $display("FAIL parity_bad_count: got loads %0d ferrs %0d expected 0 1", loads_seen - l0, ferrs_seen - f0); end
  endtask
`endif

  task automatic test_random();
    int l0;
    bit v, fs;
    l0 = loads_seen;
    for (int i = 0; i < 3000; i++) begin
      v  = $urandom_range(0, 3) != 0;
      fs = (q.size() == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 15) == 0);
      step(v, 1'($urandom_range(0, 1)), fs);
    end
    step(1'b0, 1'b0, 1'b0);
    n_checks++; if (loads_seen - l0 < 10) begin n_fail++; $display("FAIL random_loads: got %0d expected at least 10", loads_seen - l0); end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_gaps();
    test_frame_restart();
    test_idle_no_frame();
    test_reset_mid_word();
    test_back_to_back();
`ifdef SIPO_LOADER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
